ctrl_core_seq: RTL and testbench
================================

Name: ctrl_core_seq

Overview:
- Layer-level sequencer for one convolution core.
- Takes a layer command (sizes, channel counts) and drives the conv controller's core_state, in_begin, in_valid, first_input and last_input.
- Issues weight-memory and image-memory read strobes and addresses, then waits for the conv output pass to finish.
- Loops over output channels, and over input channels within each, until the layer is complete.

Parameters:
- LWIDTH, 10, width of img_size/fil_size/channel counts.
- WADDR, 16, weight memory address width.
- IADDR, 18, image memory address width.

Ports:
- clk  in  1  clock.
- xrst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle layer start pulse.
- img_size  in  LWIDTH  input image edge length.
- fil_size  in  LWIDTH  filter edge length.
- total_in  in  LWIDTH  number of input channels.
- total_out  in  LWIDTH  number of output channels.
- conv_out_end  in  1  end-of-output pulse from the conv controller.
- core_state  out  2  0=WAIT, 1=WEIGHT, 2=INPUT, 3=OUTPUT.
- conv_in_begin  out  1  in_begin pulse to the conv controller.
- conv_in_valid  out  1  pixel valid to the conv controller.
- first_input  out  1  high while the first input channel is processed.
- last_input  out  1  high while the last input channel is processed.
- mem_wt_re  out  1  weight read strobe.
- mem_wt_addr  out  WADDR  weight read address.
- mem_img_re  out  1  image read strobe.
- mem_img_addr  out  IADDR  image read address.
- out_ch  out  LWIDTH  current output channel index.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle layer-complete pulse.
- err  out  1  one-cycle pulse, coincident with done, on an illegal command.

Behaviour:
- Reset (xrst=1 at a clock edge), regardless of current state, sets:
  - state=WAIT.
  - All outputs 0; all counters and addresses 0.
  - Latched sizes 0.
- States: WAIT, WEIGHT, INPUT, OUTPUT. core_state is the registered state encoding.
- WAIT:
  - start is ignored in every other state.
  - On start, latch all four size inputs.
  - Illegal command: fil_size==0, fil_size>img_size, total_in==0 or total_out==0. Response: next cycle done=1 and err=1, state stays WAIT, busy stays 0.
  - Legal command: next cycle state=WEIGHT, busy=1, conv_in_begin=1 for that single cycle. in_ch=0, out_ch=0.
- WEIGHT:
  - Exactly fil_size*fil_size cycles, mem_wt_re=1 each cycle.
  - mem_wt_addr increments by 1 after each read.
  - mem_wt_addr is continuous across the whole layer, from 0 to total_out*total_in*fil_size^2-1. It is not reset per channel.
  - The cycle after the last read, state=INPUT.
- INPUT:
  - Exactly img_size*img_size cycles, mem_img_re=1 each cycle.
  - conv_in_valid is mem_img_re delayed 1 cycle, matching the 1-cycle memory read latency.
  - mem_img_addr = in_ch*img_size^2 + pixel index, counted incrementally with no multiplier. It restarts at 0 at the start of each output channel.
  - After the last pixel:
    - If in_ch<total_in-1: in_ch++ and go to WEIGHT.
    - Otherwise: go to OUTPUT.
- first_input = (in_ch==0) and last_input = (in_ch==total_in-1), registered and held valid throughout WEIGHT and INPUT of that channel. When total_in==1, both are high.
- OUTPUT:
  - Hold until conv_out_end=1.
  - Then, if out_ch<total_out-1: out_ch++, in_ch=0, reset mem_img_addr, go to WEIGHT and pulse conv_in_begin again.
  - Otherwise: go to WAIT with done=1 for one cycle and busy=0.
- conv_out_end in any state other than OUTPUT is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths:
  - The pixel counter uses 2*LWIDTH bits.
  - Address overflow wraps modulo 2^WADDR or 2^IADDR and is not flagged.

Test Plan:
- img=4, fil=3, in=1, out=1:
  - start at cycle 0, conv_in_begin at cycle 1.
  - WEIGHT for cycles 1–9, mem_wt_addr 0..8.
  - INPUT for cycles 10–25, mem_img_addr 0..15; conv_in_valid for cycles 11–26.
  - first_input=last_input=1.
  - OUTPUT from cycle 26. conv_out_end at cycle 40 -> done at cycle 41 with err=0.
- img=3, fil=2, in=3, out=2:
  - mem_wt_addr runs 0..23 contiguously; mem_img_addr runs 0..26 twice.
  - conv_in_begin pulses exactly twice.
  - first_input only on in_ch 0, last_input only on in_ch 2.
  - out_ch goes 0 then 1.
- fil=5, img=4 -> done=err=1 one cycle after start; busy stays 0; no strobes.
- total_out=0 -> same response as the illegal-size case.
- Second start pulse during INPUT -> ignored; the sequence is identical to the single-start run.
- xrst asserted mid-INPUT with mem_img_addr=7 -> the next cycle all outputs are 0 and state is WAIT. A new start then runs the full sequence from address 0.

Source files
------------

// File: rtl/ctrl_core_seq_if.sv
// rtl/ctrl_core_seq_if.sv - conv controller and memory read bus between the sequencer and the conv core
interface ctrl_core_seq_if #(
    parameter int WADDR = 16,
    parameter int IADDR = 18
);
    logic [1:0]       core_state;
    logic             conv_in_begin;
    logic             conv_in_valid;
    logic             first_input;
    logic             last_input;
    logic             conv_out_end;
    logic             mem_wt_re;
    logic [WADDR-1:0] mem_wt_addr;
    logic             mem_img_re;
    logic [IADDR-1:0] mem_img_addr;

    modport master (
        output core_state, conv_in_begin, conv_in_valid, first_input, last_input,
        output mem_wt_re, mem_wt_addr, mem_img_re, mem_img_addr,
        input  conv_out_end
    );

    modport slave (
        input  core_state, conv_in_begin, conv_in_valid, first_input, last_input,
        input  mem_wt_re, mem_wt_addr, mem_img_re, mem_img_addr,
        output conv_out_end
    );
endinterface

// File: rtl/ctrl_core_seq.sv
// rtl/ctrl_core_seq.sv - layer-level sequencer driving one convolution core
module ctrl_core_seq #(
    parameter int LWIDTH = 10,
    parameter int WADDR  = 16,
    parameter int IADDR  = 18
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [LWIDTH-1:0] img_size,
    input  logic [LWIDTH-1:0] fil_size,
    input  logic [LWIDTH-1:0] total_in,
    input  logic [LWIDTH-1:0] total_out,
    output logic [LWIDTH-1:0] out_ch,
    output logic              busy,
    output logic              done,
    output logic              err,
    ctrl_core_seq_if.master   bus
);
    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_WEIGHT = 2'd1;
    localparam logic [1:0] S_INPUT  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam int PW = 2 * LWIDTH;
    localparam logic [LWIDTH-1:0] L_ONE  = LWIDTH'(1);
    localparam logic [LWIDTH-1:0] L_TWO  = LWIDTH'(2);
    localparam logic [PW-1:0]     P_ONE  = PW'(1);

    logic [1:0]        state;
    logic [LWIDTH-1:0] img_r, fil_r, tin_r, tout_r;
    logic [LWIDTH-1:0] in_ch;
    logic [PW-1:0]     wt_cnt;
    logic [PW-1:0]     pix_cnt;
    logic              in_begin_r, in_valid_r, first_r, last_r;
    logic              wt_re_r, img_re_r;
    logic [WADDR-1:0]  wt_addr_r;
    logic [IADDR-1:0]  img_addr_r;

    // Per-channel cycle budgets derived from the latched command only
    logic [PW-1:0] fil_sq, img_sq;
    logic          illegal_cmd, wt_last, px_last, in_last, out_last;

    assign fil_sq      = {{LWIDTH{1'b0}}, fil_r} * {{LWIDTH{1'b0}}, fil_r};
    assign img_sq      = {{LWIDTH{1'b0}}, img_r} * {{LWIDTH{1'b0}}, img_r};
    assign wt_last     = (wt_cnt == fil_sq - P_ONE);
    assign px_last     = (pix_cnt == img_sq - P_ONE);
    assign in_last     = (in_ch + L_ONE == tin_r);
    assign out_last    = (out_ch + L_ONE == tout_r);
    assign illegal_cmd = (fil_size == '0) || (fil_size > img_size) ||
                         (total_in == '0) || (total_out == '0);

    assign bus.core_state    = state;
    assign bus.conv_in_begin = in_begin_r;
    assign bus.conv_in_valid = in_valid_r;
    assign bus.first_input   = first_r;
    assign bus.last_input    = last_r;
    assign bus.mem_wt_re     = wt_re_r;
    assign bus.mem_wt_addr   = wt_addr_r;
    assign bus.mem_img_re    = img_re_r;
    assign bus.mem_img_addr  = img_addr_r;

    // Sequencer: state, strobes, addresses and channel counters
    always_ff @(posedge clk) begin
        if (xrst) begin
            state      <= S_WAIT;
            img_r      <= '0;
            fil_r      <= '0;
            tin_r      <= '0;
            tout_r     <= '0;
            in_ch      <= '0;
            out_ch     <= '0;
            wt_cnt     <= '0;
            pix_cnt    <= '0;
            in_begin_r <= 1'b0;
            in_valid_r <= 1'b0;
            first_r    <= 1'b0;
            last_r     <= 1'b0;
            wt_re_r    <= 1'b0;
            img_re_r   <= 1'b0;
            wt_addr_r  <= '0;
            img_addr_r <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            in_begin_r <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            // Image memory answers one cycle after the read strobe
            in_valid_r <= img_re_r;
            if (wt_re_r)
                wt_addr_r <= wt_addr_r + WADDR'(1);
            if (img_re_r)
                img_addr_r <= img_addr_r + IADDR'(1);

            case (state)
                S_WAIT: begin
                    if (start) begin
                        img_r  <= img_size;
                        fil_r  <= fil_size;
                        tin_r  <= total_in;
                        tout_r <= total_out;
                        if (illegal_cmd) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state      <= S_WEIGHT;
                            busy       <= 1'b1;
                            in_begin_r <= 1'b1;
                            in_ch      <= '0;
                            out_ch     <= '0;
                            wt_cnt     <= '0;
                            wt_addr_r  <= '0;
                            img_addr_r <= '0;
                            wt_re_r    <= 1'b1;
                            first_r    <= 1'b1;
                            last_r     <= (total_in == L_ONE);
                        end
                    end
                end
                S_WEIGHT: begin
                    if (wt_last) begin
                        state    <= S_INPUT;
                        wt_cnt   <= '0;
                        wt_re_r  <= 1'b0;
                        img_re_r <= 1'b1;
                        pix_cnt  <= '0;
                    end else begin
                        wt_cnt <= wt_cnt + P_ONE;
                    end
                end
                S_INPUT: begin
                    if (px_last) begin
                        img_re_r <= 1'b0;
                        pix_cnt  <= '0;
                        if (!in_last) begin
                            state   <= S_WEIGHT;
                            in_ch   <= in_ch + L_ONE;
                            wt_re_r <= 1'b1;
                            first_r <= 1'b0;
                            last_r  <= (in_ch + L_TWO == tin_r);
                        end else begin
                            state <= S_OUTPUT;
                        end
                    end else begin
                        pix_cnt <= pix_cnt + P_ONE;
                    end
                end
                S_OUTPUT: begin
                    if (bus.conv_out_end) begin
                        if (!out_last) begin
                            state      <= S_WEIGHT;
                            out_ch     <= out_ch + L_ONE;
                            in_ch      <= '0;
                            img_addr_r <= '0;
                            in_begin_r <= 1'b1;
                            wt_re_r    <= 1'b1;
                            first_r    <= 1'b1;
                            last_r     <= (tin_r == L_ONE);
                        end else begin
                            state   <= S_WAIT;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            first_r <= 1'b0;
                            last_r  <= 1'b0;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_core_seq.sv
// tb/tb_ctrl_core_seq.sv - randomized self-checking bench for ctrl_core_seq
module tb_ctrl_core_seq;
    logic       clk = 1'b0;
    logic       xrst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] img_size = '0, fil_size = '0, total_in = '0, total_out = '0;
    logic [9:0] out_ch;
    logic       busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_core_seq_if #(.WADDR(16), .IADDR(18)) bus ();

    ctrl_core_seq #(.LWIDTH(10), .WADDR(16), .IADDR(18)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .img_size  (img_size),
        .fil_size  (fil_size),
        .total_in  (total_in),
        .total_out (total_out),
        .out_ch    (out_ch),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        bit          beg, vld, busy, done, err, wre, ire, fl, fi, li, oe;
        logic [15:0] waddr;
        logic [17:0] iaddr;
        logic [9:0]  och;
    } cyc_t;

    cyc_t q[$];
    int   beg_seen;
    int   last_waddr;

    // Expected per-cycle trace of one legal layer; index 0 is the start cycle
    task automatic build(input int img, input int fil, input int tin, input int tout, input int fixed_dly);
        cyc_t e;
        int   wa;
        bit   prev_ire;
        int   d;
        q.delete();
        wa = 0;
        prev_ire = 0;
        e = '{default: '0};
        q.push_back(e);
        for (int oc = 0; oc < tout; oc++) begin
            for (int ic = 0; ic < tin; ic++) begin
                for (int k = 0; k < fil * fil; k++) begin
                    e = '{default: '0};
                    e.st = 2'd1; e.busy = 1; e.och = 10'(oc);
                    e.beg = (ic == 0 && k == 0);
                    e.wre = 1; e.waddr = 16'(wa); wa++;
                    e.fl = 1; e.fi = (ic == 0); e.li = (ic == tin - 1);
                    e.vld = prev_ire; prev_ire = 0;
                    q.push_back(e);
                end
                for (int p = 0; p < img * img; p++) begin
                    e = '{default: '0};
                    e.st = 2'd2; e.busy = 1; e.och = 10'(oc);
                    e.ire = 1; e.iaddr = 18'(ic * img * img + p);
                    e.fl = 1; e.fi = (ic == 0); e.li = (ic == tin - 1);
                    e.vld = prev_ire; prev_ire = 1;
                    q.push_back(e);
                end
            end
            d = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 6));
            for (int j = 0; j < d; j++) begin
                e = '{default: '0};
                e.st = 2'd3; e.busy = 1; e.och = 10'(oc);
                e.oe = (j == d - 1);
                e.vld = prev_ire; prev_ire = 0;
                q.push_back(e);
            end
        end
        e = '{default: '0};
        e.done = 1;
        q.push_back(e);
        e = '{default: '0};
        q.push_back(e);
    endtask

    // Drive the trace stimulus and compare every cycle after the start
    task automatic run(input int img, input int fil, input int tin, input int tout, input bit stray);
        logic [54:0] o, x;
        int n;
        n = q.size();
        beg_seen = 0;
        last_waddr = -1;
        for (int t = 0; t < n; t++) begin
            if (t > 0) begin
                x = {q[t].st, q[t].beg, q[t].vld, q[t].busy, q[t].done, q[t].err, q[t].wre, q[t].ire,
                     q[t].fl ? {q[t].fi, q[t].li} : 2'b00,
                     q[t].wre ? q[t].waddr : 16'h0,
                     q[t].ire ? q[t].iaddr : 18'h0,
                     q[t].busy ? q[t].och : 10'h0};
                o = {bus.core_state, bus.conv_in_begin, bus.conv_in_valid, busy, done, err,
                     bus.mem_wt_re, bus.mem_img_re,
                     q[t].fl ? {bus.first_input, bus.last_input} : 2'b00,
                     q[t].wre ? bus.mem_wt_addr : 16'h0,
                     q[t].ire ? bus.mem_img_addr : 18'h0,
                     q[t].busy ? out_ch : 10'h0};
                n_tests++;
                if (o !== x) begin
                    n_fail++;
                    $display("FAIL cycle_trace t=%0d img=%0d fil=%0d in=%0d out=%0d got=%h want=%h",
                             t, img, fil, tin, tout, o, x);
                end
                if (bus.conv_in_begin) beg_seen++;
                if (bus.mem_wt_re) last_waddr = int'(bus.mem_wt_addr);
            end
            if (t == 0) begin
                start = 1'b1;
                img_size = 10'(img); fil_size = 10'(fil);
                total_in = 10'(tin); total_out = 10'(tout);
            end else begin
                start = stray && (t < n - 2) && ($urandom_range(0, 7) == 0);
                if (stray) begin
                    img_size = 10'($urandom_range(0, 9)); fil_size = 10'($urandom_range(0, 9));
                    total_in = 10'($urandom_range(0, 4)); total_out = 10'($urandom_range(0, 4));
                end
            end
            bus.conv_out_end = q[t].oe ||
                               (stray && q[t].st != 2'd3 && ($urandom_range(0, 3) == 0));
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.conv_out_end = 1'b0;
    endtask

    task automatic test_reset();
        logic [67:0] o;
        xrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        o = {bus.core_state, bus.conv_in_begin, bus.conv_in_valid, bus.first_input, bus.last_input,
             bus.mem_wt_re, bus.mem_wt_addr, bus.mem_img_re, bus.mem_img_addr, out_ch, busy, done, err};
        n_tests++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", o);
        end
        xrst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_channel();
        build(4, 3, 1, 1, 15);
        n_tests++;
        if (!(q[1].beg && q[10].st == 2'd2 && q[26].st == 2'd3 && q[40].oe && q[41].done)) begin
            n_fail++;
            $display("FAIL plan_timeline reference trace misaligned with cycle plan");
        end
        run(4, 3, 1, 1, 1'b0);
        n_tests++;
        if (beg_seen !== 1) begin
            n_fail++;
            $display("FAIL single_begin_count got=%0d want=1", beg_seen);
        end
    endtask

    task automatic test_multi_channel();
        build(3, 2, 3, 2, 0);
        run(3, 2, 3, 2, 1'b0);
        n_tests++;
        if (beg_seen !== 2) begin
            n_fail++;
            $display("FAIL multi_begin_count got=%0d want=2", beg_seen);
        end
        n_tests++;
        if (last_waddr !== 23) begin
            n_fail++;
            $display("FAIL multi_last_wt_addr got=%0d want=23", last_waddr);
        end
    endtask

    task automatic test_illegal();
        int cases[4][4] = '{'{4, 5, 1, 1}, '{4, 0, 1, 1}, '{4, 3, 0, 1}, '{4, 3, 1, 0}};
        logic [6:0] o;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            img_size = 10'(cases[i][0]); fil_size = 10'(cases[i][1]);
            total_in = 10'(cases[i][2]); total_out = 10'(cases[i][3]);
            @(posedge clk); #1;
            start = 1'b0;
            o = {done, err, busy, bus.core_state, bus.mem_wt_re, bus.mem_img_re};
            n_tests++;
            if (o !== 7'b1100000 || bus.conv_in_begin !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_response case=%0d got=%b want=1100000", i, o);
            end
            @(posedge clk); #1;
            o = {done, err, busy, bus.core_state, bus.mem_wt_re, bus.mem_img_re};
            n_tests++;
            if (o !== 7'b0000000) begin
                n_fail++;
                $display("FAIL illegal_pulse_end case=%0d got=%b want=0000000", i, o);
            end
        end
    endtask

    task automatic test_second_start();
        build(4, 3, 1, 1, 15);
        run(4, 3, 1, 1, 1'b1);
    endtask

    task automatic test_reset_mid_input();
        logic [67:0] o;
        int guard;
        start = 1'b1;
        img_size = 10'd4; fil_size = 10'd3; total_in = 10'd1; total_out = 10'd1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!(bus.mem_img_re && bus.mem_img_addr == 18'd7) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_tests++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL midreset_reach_addr7 got=timeout want=img_addr 7");
        end
        xrst = 1'b1;
        @(posedge clk); #1;
        xrst = 1'b0;
        o = {bus.core_state, bus.conv_in_begin, bus.conv_in_valid, bus.first_input, bus.last_input,
             bus.mem_wt_re, bus.mem_wt_addr, bus.mem_img_re, bus.mem_img_addr, out_ch, busy, done, err};
        n_tests++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%h want=0", o);
        end
        build(4, 3, 1, 1, 0);
        run(4, 3, 1, 1, 1'b0);
    endtask

    task automatic test_random_layers();
        int img, fil, tin, tout;
        for (int r = 0; r < 8; r++) begin
            img  = int'($urandom_range(1, 5));
            fil  = int'($urandom_range(1, img));
            tin  = int'($urandom_range(1, 3));
            tout = int'($urandom_range(1, 3));
            build(img, fil, tin, tout, 0);
            run(img, fil, tin, tout, r[0]);
        end
    endtask

    initial begin
        bus.conv_out_end = 1'b0;
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_illegal();
        test_second_start();
        test_reset_mid_input();
        test_random_layers();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
